qla_agent_ctrl: RTL and testbench
=================================

// Module: qla_agent_ctrl
// PURPOSE
//  Episode/agent controller driving the 16-bit Q-learning accelerator from the opposite side of its interface.
//  Produces st/nxtst/act/rt/stateRst and consumes the registered qRow0..3 rows.
//  Models a GRID_W x GRID_H grid world and chooses epsilon-greedy actions using an 8-bit LFSR.
//  Sequences each step as read -> decide -> single-cycle commit, and counts steps and episodes.
// PARAMETERS
//  GRID_W       8         grid columns; GRID_W*GRID_H <= 256
//  GRID_H       8         grid rows; state = row*GRID_W + col
//  START_ST     0         state loaded at each episode start
//  MAX_STEPS    64        step limit per episode (1..255)
//  REWARD_GOAL  16'sd256  rt when the move lands on goal_st
//  REWARD_WALL  -16'sd64  rt when the move is clamped at the grid edge
//  REWARD_STEP  -16'sd4   rt for any other move
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  start        in   1   level; run a batch of episodes, sampled in IDLE
//  goal_st      in   8   terminal state; sampled at start
//  num_episodes in   16  episodes in the batch; sampled at start
//  epsilon      in   8   explore threshold; explore when lfsr < epsilon
//  qRow0..3     in   16s accelerator rows (actions 0..3), valid 1 cycle after nxtst
//  stateRst     out  1   accelerator write block; low only in COMMIT
//  st, nxtst    out  8   current / next state to accelerator
//  act          out  2   0=up 1=right 2=down 3=left
//  rt           out  16s reward for the committed move
//  busy         out  1   high from EP_START through EP_END
//  done         out  1   high in DONE only
//  episode_cnt  out  16  completed episodes
//  step_cnt     out  8   steps in the current episode
// BEHAVIOUR
//  Reset values: FSM=IDLE; stateRst=1; st=nxtst=START_ST; act=0; rt=0; busy=done=0; counters=0; lfsr=8'hA5.
//  IDLE:
//   - start=1 with num_episodes=0 -> DONE.
//   - start=1 otherwise -> EP_START; goal_st and num_episodes are latched.
//  EP_START:
//   - st=nxtst=START_ST; step_cnt=0.
//   - START_ST==goal -> EP_END with no commit; otherwise -> READ.
//  READ: nxtst=st; qRow holds row(st) on the next cycle.
//  DECIDE:
//   - lfsr advances (x^8+x^6+x^5+x^4+1, shift left, feedback into bit0).
//   - new lfsr < eps -> act = lfsr[1:0].
//   - else act = argmax of signed qRow; on a tie, the lowest index wins.
//   - nxt is computed with edge clamping.
//   - rt = GOAL if nxt==goal, else WALL if clamped, else STEP.
//  COMMIT (exactly 1 cycle):
//   - stateRst=0; st=current, nxtst=nxt; act and rt are stable.
//   - The accelerator writes Q(st,act) on this edge.
//  ADVANCE:
//   - st<=nxt; step_cnt++.
//   - nxt==goal or step_cnt==MAX_STEPS -> EP_END; else -> READ.
//  EP_END:
//   - episode_cnt++.
//   - episode_cnt reaches num_episodes -> DONE; else -> EP_START.
//  DONE: done=1; start=0 -> IDLE; episode_cnt holds until the next start.
//  Step latency: 4 cycles (READ, DECIDE, COMMIT, ADVANCE).
//  stateRst is 1 in every state except COMMIT.
//  Boundaries:
//   - start while busy: ignored.
//   - rst mid-step: no COMMIT and no write occur.
//   - goal_st >= GRID_W*GRID_H: the goal is never reached; episodes end at MAX_STEPS.
//   - act, rt and nxt are registered in DECIDE and held through COMMIT.
// CONFIGURATION
//  EPS_DECAY_EN defined:
//   - An internal eps register loads epsilon at start.
//   - eps decrements by 1 at each EP_END, saturating at 0.
//  EPS_DECAY_EN undefined: epsilon is used directly every DECIDE.
// TESTING
//  T1: rst, then idle -> all outputs at reset values; stateRst=1 on every cycle.
//  T2: eps=0; qRow={5,9,9,-3}; st=0; goal=63 -> act=1, nxtst=1, rt=-4.
//   - stateRst is low exactly 1 cycle, 2 cycles after READ.
//  T3: eps=0; best act=0 at st=0 -> clamped: nxtst=0, rt=-64, st stays 0.
//  T4: START_ST=0, goal=1, qRow0..3={0,1,0,0} -> episode ends after 1 step.
//   - rt=256; episode_cnt=1; step_cnt=1.
//  T5: num_episodes=3, goal=200 -> each episode runs 64 steps.
//   - done rises after 3*(2+64*4) cycles; busy is then low.
//  T6: rst asserted during DECIDE -> the next cycle is IDLE, stateRst=1, no low pulse.
//   - With EPS_DECAY_EN and epsilon=2: eps is 2, 1, 0, 0 across 4 episodes.

Source files
------------

// File: rtl/qla_agent_ctrl.sv
// qla_agent_ctrl: episode/agent controller for the 16-bit Q-learning accelerator.
// Runs a grid-world agent (state = row*GRID_W + col) and picks epsilon-greedy
// actions using an 8-bit LFSR. Each step runs READ -> DECIDE -> COMMIT -> ADVANCE.
// The controller counts steps per episode and completed episodes in the batch.
// Optional feature macro: EPS_DECAY_EN. When it is defined, an internal epsilon
// register loads at start and decrements (saturating at 0) at each episode end.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                level request to run a batch (sampled in IDLE)
//   goal_st              terminal state, latched at start
//   num_episodes         batch size, latched at start
//   epsilon              explore threshold (explore when lfsr < epsilon)
//   qRow0..qRow3         accelerator Q row for nxtst, valid one cycle later
//   stateRst             accelerator write block, low only in COMMIT
//   st, nxtst, act, rt   transition presented to the accelerator
//   busy, done           batch status
//   episode_cnt          completed episodes in this batch
//   step_cnt             steps taken in the current episode
module qla_agent_ctrl #(
  parameter int unsigned        GRID_W      = 8,
  parameter int unsigned        GRID_H      = 8,
  parameter int unsigned        START_ST    = 0,
  parameter int unsigned        MAX_STEPS   = 64,
  parameter logic signed [15:0] REWARD_GOAL = 16'sd256,
  parameter logic signed [15:0] REWARD_WALL = -16'sd64,
  parameter logic signed [15:0] REWARD_STEP = -16'sd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         goal_st,
  input  logic [15:0]        num_episodes,
  input  logic [7:0]         epsilon,
  input  logic signed [15:0] qRow0,
  input  logic signed [15:0] qRow1,
  input  logic signed [15:0] qRow2,
  input  logic signed [15:0] qRow3,
  output logic               stateRst,
  output logic [7:0]         st,
  output logic [7:0]         nxtst,
  output logic [1:0]         act,
  output logic signed [15:0] rt,
  output logic               busy,
  output logic               done,
  output logic [15:0]        episode_cnt,
  output logic [7:0]         step_cnt
);

  localparam logic [7:0] START_S   = 8'(START_ST);
  localparam logic [7:0] MAX_S     = 8'(MAX_STEPS);
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_EP_START, S_READ, S_DECIDE, S_COMMIT, S_ADVANCE, S_EP_END, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         st_q, st_d, nxtst_q, nxtst_d;
  logic [1:0]         act_q, act_d;
  logic signed [15:0] rt_q, rt_d;
  logic               state_rst_q, state_rst_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]        ep_cnt_q, ep_cnt_d, num_ep_q, num_ep_d;
  logic [7:0]         step_cnt_q, step_cnt_d, goal_q, goal_d, lfsr_q, lfsr_d;

  // Decision datapath signals
  logic [7:0]         lfsr_nxt, eps_use, nxt_sel;
  logic [1:0]         best_act, act_sel;
  logic signed [15:0] best_val, rt_sel;
  logic               clamped;
  int unsigned        cur, row, col, nxt_int;

`ifdef EPS_DECAY_EN
  logic [7:0] eps_q;

  // Decaying epsilon: loaded at batch start, one less per finished episode
  always_ff @(posedge clk) begin
    if (rst) begin
      eps_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      eps_q <= epsilon;
    end else if (state_q == S_EP_END && eps_q != 8'd0) begin
      eps_q <= eps_q - 8'd1;
    end
  end

  assign eps_use = eps_q;
`else
  assign eps_use = epsilon;
`endif

  // Epsilon-greedy action, edge-clamped move and reward for the current state
  always_comb begin
    lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // Strict compares keep the lowest index on ties
    best_act = 2'd0;
    best_val = qRow0;
    if (qRow1 > best_val) begin best_act = 2'd1; best_val = qRow1; end
    if (qRow2 > best_val) begin best_act = 2'd2; best_val = qRow2; end
    if (qRow3 > best_val) begin best_act = 2'd3; best_val = qRow3; end
    act_sel = (lfsr_nxt < eps_use) ? lfsr_nxt[1:0] : best_act;

    cur     = 32'(st_q);
    row     = cur / GRID_W;
    col     = cur % GRID_W;
    nxt_int = cur;
    clamped = 1'b0;
    case (act_sel)
      2'd0:    if (row == 0)          clamped = 1'b1; else nxt_int = cur - GRID_W;
      2'd1:    if (col == GRID_W - 1) clamped = 1'b1; else nxt_int = cur + 1;
      2'd2:    if (row == GRID_H - 1) clamped = 1'b1; else nxt_int = cur + GRID_W;
      default: if (col == 0)          clamped = 1'b1; else nxt_int = cur - 1;
    endcase
    nxt_sel = 8'(nxt_int);

    if (nxt_sel == goal_q) rt_sel = REWARD_GOAL;
    else if (clamped)      rt_sel = REWARD_WALL;
    else                   rt_sel = REWARD_STEP;
  end

  // Next-state and register updates; the outputs follow the state being entered
  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    nxtst_d    = nxtst_q;
    act_d      = act_q;
    rt_d       = rt_q;
    ep_cnt_d   = ep_cnt_q;
    num_ep_d   = num_ep_q;
    step_cnt_d = step_cnt_q;
    goal_d     = goal_q;
    lfsr_d     = lfsr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ep_cnt_d = '0;
          if (num_episodes == 16'd0) begin
            state_d = S_DONE;
          end else begin
            goal_d   = goal_st;
            num_ep_d = num_episodes;
            state_d  = S_EP_START;
          end
        end
      end
      S_EP_START: begin
        st_d       = START_S;
        nxtst_d    = START_S;
        step_cnt_d = '0;
        state_d    = (START_S == goal_q) ? S_EP_END : S_READ;
      end
      S_READ: begin
        nxtst_d = st_q;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        lfsr_d  = lfsr_nxt;
        act_d   = act_sel;
        rt_d    = rt_sel;
        nxtst_d = nxt_sel;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        st_d       = nxtst_q;
        step_cnt_d = step_cnt_q + 8'd1;
        state_d    = (nxtst_q == goal_q || step_cnt_d == MAX_S) ? S_EP_END : S_READ;
      end
      S_EP_END: begin
        ep_cnt_d = ep_cnt_q + 16'd1;
        state_d  = (ep_cnt_d == num_ep_q) ? S_DONE : S_EP_START;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    state_rst_d = (state_d != S_COMMIT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= START_S;
      nxtst_q     <= START_S;
      act_q       <= '0;
      rt_q        <= '0;
      state_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ep_cnt_q    <= '0;
      num_ep_q    <= '0;
      step_cnt_q  <= '0;
      goal_q      <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      nxtst_q     <= nxtst_d;
      act_q       <= act_d;
      rt_q        <= rt_d;
      state_rst_q <= state_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ep_cnt_q    <= ep_cnt_d;
      num_ep_q    <= num_ep_d;
      step_cnt_q  <= step_cnt_d;
      goal_q      <= goal_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign stateRst    = state_rst_q;
  assign st          = st_q;
  assign nxtst       = nxtst_q;
  assign act         = act_q;
  assign rt          = rt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign episode_cnt = ep_cnt_q;
  assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_qla_agent_ctrl.sv
// Testbench for qla_agent_ctrl: expected commits are queued as each run is
// launched; a monitor pops and compares them whenever stateRst goes low.
module tb_qla_agent_ctrl;

  logic               clk, rst, start;
  logic [7:0]         goal_st, epsilon;
  logic [15:0]        num_episodes;
  logic signed [15:0] q0, q1, q2, q3;
  logic               stateRst, busy, done;
  logic [7:0]         st, nxtst, step_cnt;
  logic [1:0]         act;
  logic signed [15:0] rt;
  logic [15:0]        episode_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]         st;
    logic [7:0]         nxt;
    logic [1:0]         act;
    logic signed [15:0] rt;
    logic [7:0]         step;
    logic [15:0]        ep;
  } exp_t;

  exp_t sb[$];
  bit   prev_low = 1'b0;

  qla_agent_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .goal_st(goal_st),
    .num_episodes(num_episodes), .epsilon(epsilon),
    .qRow0(q0), .qRow1(q1), .qRow2(q2), .qRow3(q3),
    .stateRst(stateRst), .st(st), .nxtst(nxtst), .act(act), .rt(rt),
    .busy(busy), .done(done), .episode_cnt(episode_cnt), .step_cnt(step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic push(input int s, input int n, input int a, input int r, input int stp, input int ep);
    exp_t e;
    e.st = 8'(s); e.nxt = 8'(n); e.act = 2'(a); e.rt = 16'(r); e.step = 8'(stp); e.ep = 16'(ep);
    sb.push_back(e);
  endtask

  // Greedy "right" along row 0 from state 0: seven free moves, then the wall
  task automatic push_right_run(input int ep);
    for (int k = 0; k < 64; k++)
      push((k < 7) ? k : 7, (k + 1 < 7) ? k + 1 : 7, 1, (k < 7) ? -4 : -64, k, ep);
  endtask

  // Commit monitor: every low stateRst must match the next queued transition
  always @(negedge clk) begin
    if (!stateRst) begin
      chk("commit_pulse_width", int'(prev_low), 0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_commit: got st=%0d nxtst=%0d act=%0d required no commit", st, nxtst, act);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_st",      int'(st),          int'(e.st));
        chk("commit_nxtst",   int'(nxtst),       int'(e.nxt));
        chk("commit_act",     int'(act),         int'(e.act));
        chk("commit_rt",      int'(rt),          int'(e.rt));
        chk("commit_step",    int'(step_cnt),    int'(e.step));
        chk("commit_episode", int'(episode_cnt), int'(e.ep));
      end
    end
    prev_low = !stateRst;
  end

  task automatic set_rows(input int a, input int b, input int c, input int d);
    q0 = 16'(a); q1 = 16'(b); q2 = 16'(c); q3 = 16'(d);
  endtask

  // Launch a batch, wait (bounded) for done, then check totals and the return to IDLE
  task automatic run_batch(input string tag, input int goal, input int neps, input int eps,
                           input int exp_cyc, input int exp_ep, input int exp_step, input bit chk_step);
    int n;
    n = 0;
    @(negedge clk);
    goal_st = 8'(goal); num_episodes = 16'(neps); epsilon = 8'(eps); start = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 3000);
    chk({tag, "_cycles_to_done"}, n, exp_cyc);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_episode_cnt"}, int'(episode_cnt), exp_ep);
    if (chk_step) chk({tag, "_step_cnt"}, int'(step_cnt), exp_step);
    chk({tag, "_queue_drained"}, sb.size(), 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_cleared"}, int'(done), 0);
    chk({tag, "_episode_cnt_held"}, int'(episode_cnt), exp_ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; goal_st = 8'd63; num_episodes = 16'd1; epsilon = 8'd0;
    set_rows(0, 0, 0, 0);

    // T1: reset and idle values
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle_stateRst", int'(stateRst), 1);
      chk("idle_busy", int'(busy), 0);
    end
    chk("reset_st", int'(st), 0);
    chk("reset_nxtst", int'(nxtst), 0);
    chk("reset_act", int'(act), 0);
    chk("reset_rt", int'(rt), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_episode_cnt", int'(episode_cnt), 0);
    chk("reset_step_cnt", int'(step_cnt), 0);

    // Exploration from the reset seed: lfsr 4A, 95, 2A -> act 2, 1, 2
    set_rows(100, 0, 0, 0);
    push(0, 8, 2, -4, 0, 0);
    push(8, 9, 1, -4, 1, 0);
    push(9, 17, 2, 256, 2, 0);
    run_batch("explore", 17, 1, 255, 15, 1, 3, 1);

    // T4: goal one step to the right
    set_rows(0, 1, 0, 0);
    push(0, 1, 1, 256, 0, 0);
    run_batch("goal_one_step", 1, 1, 0, 7, 1, 1, 1);

    // T2: tie between actions 1 and 2 resolves to 1
    set_rows(5, 9, 9, -3);
    push_right_run(0);
    run_batch("tie_right", 63, 1, 0, 259, 1, 64, 1);

    // T3: greedy "up" from row 0 is clamped every step
    set_rows(9, 0, 0, 0);
    for (int k = 0; k < 64; k++) push(0, 0, 0, -64, k, 0);
    run_batch("wall_up", 63, 1, 0, 259, 1, 64, 1);

    // T5: unreachable goal, three full-length episodes
    set_rows(0, 1, 0, 0);
    for (int e = 0; e < 3; e++) push_right_run(e);
    run_batch("three_ep", 200, 3, 0, 775, 3, 64, 1);

    // Zero episodes goes straight to DONE
    run_batch("zero_ep", 63, 0, 0, 1, 0, 0, 0);

    // Goal equal to the start state: episodes end without any commit
    run_batch("goal_at_start", 0, 2, 0, 5, 2, 0, 1);

    // T6: reset lands during DECIDE; no commit may follow
    set_rows(0, 1, 0, 0);
    @(negedge clk);
    goal_st = 8'd63; num_episodes = 16'd1; epsilon = 8'd0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_decide_stateRst", int'(stateRst), 1);
    chk("rst_decide_busy", int'(busy), 0);
    chk("rst_decide_nxtst", int'(nxtst), 0);
    chk("rst_decide_act", int'(act), 0);
    chk("rst_decide_rt", int'(rt), 0);
    chk("rst_decide_episode_cnt", int'(episode_cnt), 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_stateRst", int'(stateRst), 1);
      chk("post_rst_busy", int'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
